// File: rtl/mem_ctrl.sv
// mem_ctrl: byte-serial memory controller arbitrating a load/store port and an
// instruction-fetch port onto a single 8-bit RAM interface.
// Each port has a single pending slot. The load/store port always wins arbitration.
// An access of N bytes completes N edges after it starts. A pipeline flush drops
// reads but never drops stores.
// Optional feature: define IO_STALL_EN to hold back write bytes that target the
// IO window (address >= IO_ADDR_BASE) while io_buffer_full is high.
module mem_ctrl #(
  parameter logic [31:0] IO_ADDR_BASE = 32'h00030000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        ena_from_ls,
  input  logic [31:0] addr_from_ls,
  input  logic [31:0] data_from_ls,
  input  logic        wr_flag_from_ls,
  input  logic [2:0]  size_from_ls,
  output logic        ok_flag_to_ls,
  output logic [31:0] data_to_ls,
  input  logic        ena_from_if,
  input  logic [31:0] addr_from_if,
  output logic        ok_flag_to_if,
  output logic [31:0] data_to_if,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full,
  input  logic        commit_jump_flag,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {IDLE, LS_READ, LS_WRITE, IF_READ} state_t;
  state_t state, state_nx;

  // Pending request slots, one per port
  logic        ls_pend, ls_wr;
  logic [31:0] ls_addr, ls_data;
  logic [2:0]  ls_size;
  logic        if_pend;
  logic [31:0] if_addr;

  // In-flight access: cnt is the index of the next byte to present
  logic [31:0] cur_addr, cur_data, asm_q, asm_nx, issue_addr;
  logic [2:0]  cur_size, cnt;
  logic [7:0]  wr_byte;
  logic        mem_wr_q;
  logic        start_ls, start_if, step, stall, finish, abort;
  logic        ls_go, if_go, last, stall_hit;

  // The RAM write strobe is forced low while rdy is low, even mid-access
  assign mem_wr    = mem_wr_q & rdy;
  assign state_dbg = state;
  assign last      = (cnt >= cur_size);
  // A flush drops reads that would otherwise start on this very edge
  assign ls_go     = ls_pend && !(commit_jump_flag && !ls_wr);
  assign if_go     = if_pend && !commit_jump_flag;
  // Address of the write byte about to be issued (byte 0 when starting from IDLE)
  assign issue_addr = (state == IDLE) ? ls_addr : (cur_addr + {29'd0, cnt});

`ifdef IO_STALL_EN
  assign stall_hit = io_buffer_full && (issue_addr >= IO_ADDR_BASE);
`else
  logic unused_io;
  assign stall_hit = 1'b0;
  assign unused_io = io_buffer_full | (|IO_ADDR_BASE) | (|issue_addr);
`endif

  // Select the byte of the in-flight store data addressed by cnt
  always_comb begin
    wr_byte = 8'd0;
    case (cnt)
      3'd0:    wr_byte = cur_data[7:0];
      3'd1:    wr_byte = cur_data[15:8];
      3'd2:    wr_byte = cur_data[23:16];
      3'd3:    wr_byte = cur_data[31:24];
      default: wr_byte = 8'd0;
    endcase
  end

  // Merge the RAM byte returned for the previously presented address
  always_comb begin
    asm_nx = asm_q;
    case (cnt)
      3'd1:    asm_nx[7:0]   = mem_din;
      3'd2:    asm_nx[15:8]  = mem_din;
      3'd3:    asm_nx[23:16] = mem_din;
      3'd4:    asm_nx[31:24] = mem_din;
      default: asm_nx = asm_q;
    endcase
  end

  // Next-state and per-edge control decode
  always_comb begin
    state_nx = state;
    start_ls = 1'b0;
    start_if = 1'b0;
    step     = 1'b0;
    stall    = 1'b0;
    finish   = 1'b0;
    abort    = 1'b0;
    case (state)
      IDLE: begin
        if (ls_go) begin
          start_ls = 1'b1;
          state_nx = ls_wr ? LS_WRITE : LS_READ;
        end else if (if_go) begin
          start_if = 1'b1;
          state_nx = IF_READ;
        end
      end
      LS_READ, IF_READ: begin
        if (commit_jump_flag) begin
          abort    = 1'b1;
          state_nx = IDLE;
        end else if (last) begin
          finish   = 1'b1;
          state_nx = IDLE;
        end else begin
          step = 1'b1;
        end
      end
      LS_WRITE: begin
        if (last) begin
          finish   = 1'b1;
          state_nx = IDLE;
        end else if (stall_hit) begin
          stall = 1'b1;
        end else begin
          step = 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
    if (!rdy) begin
      state_nx = state;
      start_ls = 1'b0;
      start_if = 1'b0;
      step     = 1'b0;
      stall    = 1'b0;
      finish   = 1'b0;
      abort    = 1'b0;
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Datapath: pending slots, byte sequencing, read assembly and completion pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ls_pend <= 1'b0; ls_wr <= 1'b0; ls_addr <= '0; ls_data <= '0; ls_size <= '0;
      if_pend <= 1'b0; if_addr <= '0;
      cur_addr <= '0; cur_data <= '0; cur_size <= '0; cnt <= '0; asm_q <= '0;
      ok_flag_to_ls <= 1'b0; ok_flag_to_if <= 1'b0;
      data_to_ls <= '0; data_to_if <= '0;
      mem_a <= '0; mem_dout <= '0; mem_wr_q <= 1'b0;
    end else if (rdy) begin
      ok_flag_to_ls <= 1'b0;
      ok_flag_to_if <= 1'b0;
      if (commit_jump_flag) begin
        if_pend <= 1'b0;
        if (!ls_wr) ls_pend <= 1'b0;
      end
      if (start_ls) begin
        ls_pend  <= 1'b0;
        cur_addr <= ls_addr;
        cur_data <= ls_data;
        cur_size <= ls_size;
        asm_q    <= '0;
        mem_a    <= ls_addr;
        if (ls_wr && stall_hit) begin
          mem_wr_q <= 1'b0;
          cnt      <= 3'd0;
        end else begin
          mem_wr_q <= ls_wr;
          if (ls_wr) mem_dout <= ls_data[7:0];
          cnt <= 3'd1;
        end
      end
      if (start_if) begin
        if_pend  <= 1'b0;
        cur_addr <= if_addr;
        cur_size <= 3'd4;
        asm_q    <= '0;
        mem_a    <= if_addr;
        mem_wr_q <= 1'b0;
        cnt      <= 3'd1;
      end
      if (step) begin
        mem_a <= cur_addr + {29'd0, cnt};
        cnt   <= cnt + 3'd1;
        if (state == LS_WRITE) begin
          mem_wr_q <= 1'b1;
          mem_dout <= wr_byte;
        end else begin
          asm_q <= asm_nx;
        end
      end
      if (stall || abort) mem_wr_q <= 1'b0;
      if (finish) begin
        mem_wr_q <= 1'b0;
        if (state == IF_READ) begin
          data_to_if    <= asm_nx;
          ok_flag_to_if <= 1'b1;
        end else begin
          ok_flag_to_ls <= 1'b1;
          if (state == LS_READ) data_to_ls <= asm_nx;
        end
      end
      if (ena_from_ls && !(commit_jump_flag && !wr_flag_from_ls)) begin
        ls_pend <= 1'b1;
        ls_wr   <= wr_flag_from_ls;
        ls_addr <= addr_from_ls;
        ls_data <= data_from_ls;
        ls_size <= size_from_ls;
      end
      if (ena_from_if && !commit_jump_flag) begin
        if_pend <= 1'b1;
        if_addr <= addr_from_if;
      end
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: bench for mem_ctrl with a behavioural byte RAM, a vector table of
// load/store accesses and hand-written sequences for arbitration, flush, rdy,
// reset and IO-window corner cases.
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst, rdy;
  logic        ena_from_ls, wr_flag_from_ls;
  logic [31:0] addr_from_ls, data_from_ls;
  logic [2:0]  size_from_ls;
  logic        ok_flag_to_ls, ok_flag_to_if;
  logic [31:0] data_to_ls, data_to_if;
  logic        ena_from_if;
  logic [31:0] addr_from_if;
  logic [7:0]  mem_din, mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr, io_buffer_full, commit_jump_flag;
  logic [1:0]  state_dbg;

  int checks = 0;
  int errors = 0;

  // Bit 32 set: compare data_to_ls; clear: completion of a store
  logic [32:0] exp_ls_q[$];
  logic [31:0] exp_if_q[$];
  logic [32:0] e_ls;
  logic [31:0] e_if;

  logic [7:0] ram [0:4095];

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [2:0]  size;
    logic [31:0] exp_data;
    int          lat;
  } vec_t;
  vec_t vec [10];

  always #5 clk = ~clk;

  mem_ctrl dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .ena_from_ls(ena_from_ls), .addr_from_ls(addr_from_ls), .data_from_ls(data_from_ls),
    .wr_flag_from_ls(wr_flag_from_ls), .size_from_ls(size_from_ls),
    .ok_flag_to_ls(ok_flag_to_ls), .data_to_ls(data_to_ls),
    .ena_from_if(ena_from_if), .addr_from_if(addr_from_if),
    .ok_flag_to_if(ok_flag_to_if), .data_to_if(data_to_if),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full), .commit_jump_flag(commit_jump_flag),
    .state_dbg(state_dbg)
  );

  // RAM: read data follows the registered address; writes land on the clock edge
  always_comb mem_din = ram[mem_a[11:0]];
  always @(posedge clk) if (mem_wr) ram[mem_a[11:0]] <= mem_dout;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b expected=%b", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_pulses();
    ena_from_ls      = 1'b0;
    ena_from_if      = 1'b0;
    commit_jump_flag = 1'b0;
  endtask

  task automatic drive_ls(input logic wr, input logic [31:0] a, input logic [31:0] d,
                          input logic [2:0] sz, input logic [31:0] exp);
    ena_from_ls     = 1'b1;
    wr_flag_from_ls = wr;
    addr_from_ls    = a;
    data_from_ls    = d;
    size_from_ls    = sz;
    exp_ls_q.push_back({~wr, exp});
  endtask

  // Counts edges from the request pulse edge (1) to the completion pulse
  task automatic wait_ok(input bit is_if, input int exp_lat, input string name);
    int n;
    n = 0;
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (c == 1) clear_pulses();
      if (is_if ? ok_flag_to_if : ok_flag_to_ls) begin
        n = c;
        break;
      end
    end
    check(name, n, exp_lat);
    tick();
    check_bit({name, "_pulse_width"}, is_if ? ok_flag_to_if : ok_flag_to_ls, 1'b0);
    check_bit({name, "_idle_wr"}, mem_wr, 1'b0);
  endtask

  task automatic count_ls_ok(input int cycles, output int n);
    n = 0;
    for (int c = 0; c < cycles; c++) begin
      tick();
      if (ok_flag_to_ls) n++;
    end
  endtask

  // Scoreboard: pop an expectation for every completion pulse
  always @(posedge clk) begin
    #1;
    if (ok_flag_to_ls) begin
      if (exp_ls_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL ls_ok_unexpected actual=1 expected=0");
      end else begin
        e_ls = exp_ls_q.pop_front();
        if (e_ls[32]) check("ls_data", data_to_ls, e_ls[31:0]);
      end
    end
    if (ok_flag_to_if) begin
      if (exp_if_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL if_ok_unexpected actual=1 expected=0");
      end else begin
        e_if = exp_if_q.pop_front();
        check("if_data", data_to_if, e_if);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, ls_c, if_c;
    rst = 1'b0; rdy = 1'b1; io_buffer_full = 1'b0;
    clear_pulses();
    wr_flag_from_ls = 1'b0; addr_from_ls = '0; data_from_ls = '0; size_from_ls = '0;
    addr_from_if = '0;
    for (int i = 0; i < 4096; i++) ram[i] = i[7:0];
    ram[12'h100] = 8'h11; ram[12'h101] = 8'h22; ram[12'h102] = 8'h33; ram[12'h103] = 8'h44;

    vec[0] = '{1'b0, 32'h100, 32'h0,        3'd4, 32'h44332211, 6};
    vec[1] = '{1'b0, 32'h101, 32'h0,        3'd1, 32'h00000022, 3};
    vec[2] = '{1'b0, 32'h102, 32'h0,        3'd2, 32'h00004433, 4};
    vec[3] = '{1'b1, 32'h200, 32'hAABBCCDD, 3'd2, 32'h0,        4};
    vec[4] = '{1'b0, 32'h200, 32'h0,        3'd4, 32'h0302CCDD, 6};
    vec[5] = '{1'b1, 32'h303, 32'h12345699, 3'd1, 32'h0,        3};
    vec[6] = '{1'b0, 32'h302, 32'h0,        3'd2, 32'h00009902, 4};
    vec[7] = '{1'b1, 32'h7FC, 32'hCAFEF00D, 3'd4, 32'h0,        6};
    vec[8] = '{1'b0, 32'h7FC, 32'h0,        3'd4, 32'hCAFEF00D, 6};
    vec[9] = '{1'b0, 32'h7FF, 32'h0,        3'd1, 32'h000000CA, 3};

    // Reset values
    #2 rst = 1'b1;
    tick(); tick();
    check("rst_state", {30'd0, state_dbg}, 32'd0);
    check("rst_mem_a", mem_a, 32'd0);
    check("rst_mem_dout", {24'd0, mem_dout}, 32'd0);
    check_bit("rst_mem_wr", mem_wr, 1'b0);
    check_bit("rst_ok_ls", ok_flag_to_ls, 1'b0);
    check_bit("rst_ok_if", ok_flag_to_if, 1'b0);
    check("rst_data_ls", data_to_ls, 32'd0);
    check("rst_data_if", data_to_if, 32'd0);
    rst = 1'b0;
    tick();

    // Vector table: mixed sizes, unaligned, write-then-read
    for (int i = 0; i < 10; i++) begin
      drive_ls(vec[i].wr, vec[i].addr, vec[i].data, vec[i].size, vec[i].exp_data);
      wait_ok(1'b0, vec[i].lat, $sformatf("vec%0d_latency", i));
    end

    // Halfword store, edge by edge
    drive_ls(1'b1, 32'h200, 32'hAABBCCDD, 3'd2, 32'h0);
    tick(); clear_pulses();
    tick();
    check_bit("sh_e0_wr", mem_wr, 1'b1);
    check("sh_e0_a", mem_a, 32'h200);
    check("sh_e0_dout", {24'd0, mem_dout}, 32'hDD);
    tick();
    check_bit("sh_e1_wr", mem_wr, 1'b1);
    check("sh_e1_a", mem_a, 32'h201);
    check("sh_e1_dout", {24'd0, mem_dout}, 32'hCC);
    tick();
    check_bit("sh_e2_wr", mem_wr, 1'b0);
    check_bit("sh_e2_ok", ok_flag_to_ls, 1'b1);
    tick();

    // Same-cycle IF and LS: LS first, IF starts after
    ena_from_if = 1'b1; addr_from_if = 32'h0;
    exp_if_q.push_back(32'h03020100);
    drive_ls(1'b0, 32'h10, 32'h0, 3'd1, 32'h10);
    ls_c = 0; if_c = 0;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (c == 1) clear_pulses();
      if (ok_flag_to_ls && ls_c == 0) ls_c = c;
      if (ok_flag_to_if && if_c == 0) if_c = c;
    end
    check("arb_ls_latency", ls_c, 3);
    check("arb_if_latency", if_c, 8);

    // Fetch aborted by flush; a store queued meanwhile still runs
    ena_from_if = 1'b1; addr_from_if = 32'h40;
    tick(); clear_pulses();
    drive_ls(1'b1, 32'h50, 32'h00000077, 3'd1, 32'h0);
    tick(); clear_pulses();
    tick();
    commit_jump_flag = 1'b1;
    tick(); clear_pulses();
    check("abort_state_idle", {30'd0, state_dbg}, 32'd0);
    check_bit("abort_wr", mem_wr, 1'b0);
    tick();
    check_bit("abort_sb_wr", mem_wr, 1'b1);
    check("abort_sb_a", mem_a, 32'h50);
    check("abort_sb_dout", {24'd0, mem_dout}, 32'h77);
    tick();
    check_bit("abort_sb_ok", ok_flag_to_ls, 1'b1);
    for (int c = 0; c < 6; c++) tick();
    drive_ls(1'b0, 32'h50, 32'h0, 3'd1, 32'h77);
    wait_ok(1'b0, 3, "abort_sb_readback");

    // Read pulse coinciding with flush is dropped
    ena_from_ls = 1'b1; wr_flag_from_ls = 1'b0; addr_from_ls = 32'h100; size_from_ls = 3'd4;
    commit_jump_flag = 1'b1;
    tick(); clear_pulses();
    count_ls_ok(8, n);
    check("flush_pulse_read_dropped", n, 0);
    // Pending read flushed before it starts
    ena_from_ls = 1'b1; wr_flag_from_ls = 1'b0; addr_from_ls = 32'h100; size_from_ls = 3'd4;
    tick(); clear_pulses();
    commit_jump_flag = 1'b1;
    tick(); clear_pulses();
    count_ls_ok(8, n);
    check("flush_pending_read_dropped", n, 0);
    // Store pulse coinciding with flush is kept
    drive_ls(1'b1, 32'h60, 32'hBEEF00A5, 3'd1, 32'h0);
    commit_jump_flag = 1'b1;
    wait_ok(1'b0, 3, "flush_store_kept");
    drive_ls(1'b0, 32'h60, 32'h0, 3'd1, 32'hA5);
    wait_ok(1'b0, 3, "flush_store_readback");

    // rdy low mid-store: strobe forced low, state frozen, fetch pulse ignored
    drive_ls(1'b1, 32'h400, 32'h11223344, 3'd4, 32'h0);
    tick(); clear_pulses();
    tick();
    check_bit("rdy_e0_wr", mem_wr, 1'b1);
    rdy = 1'b0;
    #1;
    check_bit("rdy_low_wr_comb", mem_wr, 1'b0);
    ena_from_if = 1'b1; addr_from_if = 32'h40;
    for (int c = 0; c < 3; c++) begin
      tick();
      clear_pulses();
      check_bit("rdy_low_wr", mem_wr, 1'b0);
      check("rdy_low_a_held", mem_a, 32'h400);
    end
    rdy = 1'b1;
    n = 0;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (ok_flag_to_ls) begin
        n = c;
        break;
      end
    end
    check("rdy_resume_latency", n, 4);
    tick();
    drive_ls(1'b0, 32'h400, 32'h0, 3'd4, 32'h11223344);
    wait_ok(1'b0, 6, "rdy_readback");

    // Reset in the middle of a word load
    ena_from_ls = 1'b1; wr_flag_from_ls = 1'b0; addr_from_ls = 32'h100; size_from_ls = 3'd4;
    tick(); clear_pulses();
    tick(); tick(); tick();
    rst = 1'b1;
    #1;
    check("midrst_state", {30'd0, state_dbg}, 32'd0);
    check("midrst_mem_a", mem_a, 32'd0);
    check_bit("midrst_mem_wr", mem_wr, 1'b0);
    check("midrst_data_ls", data_to_ls, 32'd0);
    tick();
    rst = 1'b0;
    count_ls_ok(8, n);
    check("midrst_no_ok", n, 0);
    drive_ls(1'b0, 32'h100, 32'h0, 3'd4, 32'h44332211);
    wait_ok(1'b0, 6, "midrst_next_lw");

    // Byte store into the IO window with the output buffer full
`ifdef IO_STALL_EN
    io_buffer_full = 1'b1;
    drive_ls(1'b1, 32'h30000, 32'h5A, 3'd1, 32'h0);
    tick(); clear_pulses();
    for (int c = 0; c < 3; c++) begin
      tick();
      check_bit("io_stall_wr", mem_wr, 1'b0);
    end
    io_buffer_full = 1'b0;
    tick();
    check_bit("io_issue_wr", mem_wr, 1'b1);
    check("io_issue_a", mem_a, 32'h30000);
    check("io_issue_dout", {24'd0, mem_dout}, 32'h5A);
    tick();
    check_bit("io_ok", ok_flag_to_ls, 1'b1);
    tick();
`else
    io_buffer_full = 1'b1;
    drive_ls(1'b1, 32'h30000, 32'h5A, 3'd1, 32'h0);
    wait_ok(1'b0, 3, "io_full_ignored_latency");
    io_buffer_full = 1'b0;
`endif

    tick(); tick();
    checks++;
    if (exp_ls_q.size() != 0 || exp_if_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain actual=%0d/%0d expected=0/0", exp_ls_q.size(), exp_if_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
